// File: rtl/bitslip_aligner_pkg.sv
// Shared types and helpers for the bitslip word aligner.
// Defines align_state_t, the widest supported word and the idle-word builder.
package bitslip_aligner_pkg;

  localparam int MAX_DW = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  // All-ones word of width w, the level an idle line deserialises to.
  function automatic logic [MAX_DW-1:0] idle_word(input int w);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      r[i] = (i < w);
    end
    return r;
  endfunction

endpackage

// File: rtl/bitslip_align_ch.sv
// One channel of the aligner: FSM, match/slip/settle counters, outputs.
// Ports: clk, rst, retrain, en, train, word in; bitslip, aligned, fail out;
// slip_cnt out only when BITSLIP_ALIGNER_SLIP_CNT_EN is defined.
module bitslip_align_ch
  import bitslip_aligner_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(10),
  parameter int MATCH_COUNT = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_SLIPS = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  retrain,
  input  logic                  en,
  input  logic                  train,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  bitslip,
  output logic                  aligned,
  output logic                  fail
`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
  ,
  output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt
`endif
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(MAX_SLIPS);
  localparam logic [MCW-1:0] MATCH_MAX   = MCW'(MATCH_COUNT);
  localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);

  localparam logic [MAX_DW-1:0] IDLE_FULL = idle_word(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = IDLE_FULL[DATA_WIDTH-1:0];

  align_state_t state;
  align_state_t state_nx;

  logic [MCW-1:0] match_cnt;
  logic [SCW-1:0] slip_cnt_q;
  logic [STW-1:0] settle_cnt;

  logic is_match;
  logic is_idle;

  assign is_match = (word == TRAIN_PATTERN);
  assign is_idle  = (word == IDLE_WORD);

  always_ff @(posedge clk) begin
    if (rst || retrain) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (train) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (en) begin
          if (!train) begin
            state_nx = ST_IDLE;
          end else if (is_match) begin
            if (match_cnt == MATCH_LAST) state_nx = ST_LOCKED;
          end else if (!is_idle) begin
            state_nx = (slip_cnt_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
          end
        end
      end
      ST_SLIP: state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nx = ST_CHECK;
      end
      ST_LOCKED: state_nx = ST_LOCKED;
      ST_FAIL: state_nx = ST_FAIL;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counters saturate; the idle word holds the match run without breaking it.
  always_ff @(posedge clk) begin
    if (rst || retrain) begin
      match_cnt  <= '0;
      slip_cnt_q <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          match_cnt  <= '0;
          slip_cnt_q <= '0;
          settle_cnt <= '0;
        end
        ST_CHECK: begin
          if (en && train) begin
            if (is_match) begin
              if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + 1'b1;
            end else if (!is_idle) begin
              match_cnt <= '0;
            end
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q != SLIP_MAX) slip_cnt_q <= slip_cnt_q + 1'b1;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bitslip = 1'b0;
    aligned = 1'b0;
    fail    = 1'b0;
    unique case (state)
      ST_SLIP:   bitslip = 1'b1;
      ST_LOCKED: aligned = 1'b1;
      ST_FAIL:   fail    = 1'b1;
      default: ;
    endcase
  end

`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
  assign slip_cnt = slip_cnt_q;
`endif

endmodule

// File: rtl/bitslip_aligner.sv
// Multi-channel deserialiser word aligner: per-channel bitslip until lock.
// Ports: clk, rst, en, train, retrain, data_in in; bitslip, aligned, fail,
// all_aligned out; slip_count out with BITSLIP_ALIGNER_SLIP_CNT_EN defined.
module bitslip_aligner
  import bitslip_aligner_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(10),
  parameter int MATCH_COUNT = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_SLIPS = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         train,
  input  logic                         retrain,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            bitslip,
  output logic [NUM_CH-1:0]            aligned,
  output logic [NUM_CH-1:0]            fail,
  output logic                         all_aligned
`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
  ,
  output logic [NUM_CH*$clog2(MAX_SLIPS+1)-1:0] slip_count
`endif
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bitslip_align_ch #(
      .DATA_WIDTH    (DATA_WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .retrain (retrain),
      .en      (en),
      .train   (train),
      .word    (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .bitslip (bitslip[i]),
      .aligned (aligned[i]),
      .fail    (fail[i])
`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
      ,
      .slip_cnt (slip_count[i*SCW +: SCW])
`endif
    );
  end

  // Cleared by retrain too, so it never lags one cycle behind a drop.
  always_ff @(posedge clk) begin
    if (rst || retrain) begin
      all_aligned <= 1'b0;
    end else begin
      all_aligned <= &aligned;
    end
  end

endmodule

// File: tb/tb_bitslip_aligner.sv
// Directed bench for bitslip_aligner with a rotating deserialiser model.
// Each bitslip pulse removes one bit of rotation from the modelled channel.
module tb_bitslip_aligner;

  localparam int NC = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic train;
  logic retrain;
  logic [NC*DW-1:0] data_in;
  logic [NC-1:0] bitslip;
  logic [NC-1:0] aligned;
  logic [NC-1:0] fail;
  logic all_aligned;
`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
  logic [NC*5-1:0] slip_count;
`endif

  always #5 clk = ~clk;

  bitslip_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .train       (train),
    .retrain     (retrain),
    .data_in     (data_in),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .fail        (fail),
    .all_aligned (all_aligned)
`ifdef BITSLIP_ALIGNER_SLIP_CNT_EN
    ,
    .slip_count  (slip_count)
`endif
  );

  int ntests = 0;
  int nfail = 0;

  int rot[NC];
  logic cmode[NC];
  logic [7:0] cword[NC];
  int pulses[NC];
  int last_p[NC];
  int min_gap[NC];
  int lock_t[NC];
  int fail_t[NC];
  int all_t;
  int tick_no;
  logic ov_on;
  logic [7:0] seq[5];
  int seen;

  task automatic chk(input string tag, input int got, input int exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [7:0] w;
    for (int c = 0; c < NC; c++) begin
      w = (8'h0A << rot[c]) | (8'h0A >> (8 - rot[c]));
      if (cmode[c]) w = cword[c];
      if (c == 0 && ov_on && tick_no >= 1 && tick_no <= 5) w = seq[tick_no-1];
      data_in[c*DW +: DW] = w;
    end
  endtask

  task automatic clear();
    tick_no = 0;
    all_t = -1;
    for (int c = 0; c < NC; c++) begin
      pulses[c] = 0;
      last_p[c] = -1;
      min_gap[c] = 1000;
      lock_t[c] = -1;
      fail_t[c] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    for (int c = 0; c < NC; c++) begin
      if (bitslip[c]) begin
        pulses[c]++;
        if (last_p[c] >= 0 && tick_no - last_p[c] < min_gap[c])
          min_gap[c] = tick_no - last_p[c];
        last_p[c] = tick_no;
        if (!cmode[c]) rot[c] = (rot[c] + 7) % 8;
      end
      if (aligned[c] && lock_t[c] < 0) lock_t[c] = tick_no;
      if (fail[c] && fail_t[c] < 0) fail_t[c] = tick_no;
    end
    if (all_aligned && all_t < 0) all_t = tick_no;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    train = 1'b0;
    retrain = 1'b0;
    en = 1'b1;
    ov_on = 1'b0;
    for (int c = 0; c < NC; c++) begin
      rot[c] = 0;
      cmode[c] = 1'b0;
      cword[c] = 8'h00;
    end
    drive();
    tick();
    tick();
    rst = 1'b0;
    clear();
  endtask

  initial begin
    seq[0] = 8'h0A;
    seq[1] = 8'hFF;
    seq[2] = 8'h0A;
    seq[3] = 8'h0A;
    seq[4] = 8'h0A;
    tick_no = 0;
    do_reset();
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_all", int'(all_aligned), 0);

    // in-pattern channels lock after four words
    train = 1'b1;
    drive();
    run(10);
    chk("s1_lock0", lock_t[0], 5);
    chk("s1_pulses0", pulses[0], 0);
    chk("s1_all", all_t, 6);

    // en low stalls comparisons
    do_reset();
    rot[0] = 2;
    en = 1'b0;
    train = 1'b1;
    drive();
    run(10);
    chk("en_pulses0", pulses[0], 0);
    chk("en_aligned", int'(aligned), 0);
    en = 1'b1;
    clear();
    run(20);
    chk("en_lock0", lock_t[0], 12);
    chk("en_lock1", lock_t[1], 4);
    chk("en_pulses0b", pulses[0], 2);

    // offsets 0/1/5/7
    do_reset();
    rot[1] = 1;
    rot[2] = 5;
    rot[3] = 7;
    train = 1'b1;
    drive();
    run(40);
    chk("ofs_lock0", lock_t[0], 5);
    chk("ofs_lock1", lock_t[1], 9);
    chk("ofs_lock2", lock_t[2], 25);
    chk("ofs_lock3", lock_t[3], 33);
    chk("ofs_pulses2", pulses[2], 5);
    chk("ofs_pulses3", pulses[3], 7);
    chk("ofs_gap3", min_gap[3], 4);
    chk("ofs_all", all_t, 34);

    // rotate-by-3 lock beside a channel that never matches
    do_reset();
    rot[0] = 3;
    cmode[1] = 1'b1;
    cword[1] = 8'h55;
    train = 1'b1;
    drive();
    run(75);
    chk("r3_lock0", lock_t[0], 17);
    chk("r3_pulses0", pulses[0], 3);
    chk("r3_gap0", min_gap[0], 4);
    chk("r3_fail0", fail_t[0], -1);
    chk("f_pulses1", pulses[1], 16);
    chk("f_fail1", fail_t[1], 66);
    chk("f_lock1", lock_t[1], -1);
    chk("f_gap1", min_gap[1], 4);
    chk("f_lock2", lock_t[2], 5);
    chk("f_all", all_t, -1);
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk("rt_fail", int'(fail), 0);
    chk("rt_aligned_f", int'(aligned), 0);
    cmode[1] = 1'b0;

    // idle word holds the match run
    do_reset();
    ov_on = 1'b1;
    train = 1'b1;
    drive();
    run(10);
    ov_on = 1'b0;
    chk("idle_lock0", lock_t[0], 6);
    chk("idle_pulses0", pulses[0], 0);
    chk("idle_all", all_t, 7);

    // retrain after lock
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk("rt_aligned", int'(aligned), 0);
    chk("rt_all", int'(all_aligned), 0);
    chk("rt_bitslip", int'(bitslip), 0);
    clear();
    run(10);
    chk("rt_lock0", lock_t[0], 5);
    chk("rt_all_t", all_t, 6);

    // reset during SLIP
    do_reset();
    rot[1] = 3;
    train = 1'b1;
    drive();
    seen = -1;
    for (int i = 0; i < 10 && seen < 0; i++) begin
      tick();
      if (bitslip[1]) seen = tick_no;
    end
    chk("rs_slip_at", seen, 2);
    rst = 1'b1;
    tick();
    chk("rs_bitslip", int'(bitslip), 0);
    chk("rs_aligned", int'(aligned), 0);
    rst = 1'b0;
    clear();
    run(20);
    chk("rs_lock1", lock_t[1], 13);
    chk("rs_pulses1", pulses[1], 2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
